// File: rtl/bus_timer.sv
// ---------------------------------------------------------------------------
// bus_timer -- register-mapped interval timer on the 8-bit device bus.
//
// A prescaled 16-bit down-counter with a sticky expiry flag, optional
// auto-reload and a registered level interrupt. It answers the same
// strobe/read/write protocol as the UART that shares the bus.
//
// Register map (i_addr):
//   0 CTRL      RW  bit0 en, bit1 auto, bit2 ie, bit3 out_force_low (PWM build)
//   1 PRESCALE  RW  tick every PRESCALE+1 cycles while running
//   2 RELOAD_LO RW
//   3 RELOAD_HI RW
//   4 COUNT_LO  RO  also latches COUNT[15:8] into the shadow
//   5 COUNT_HI  RO  returns the shadow
//   6 STATUS    RW  bit0 expired; any write clears it
//   7..15           read 0, writes ignored
//
// Ports:
//   i_clk   system clock, posedge
//   i_rst   synchronous reset, active-high
//   i_en    bus cycle strobe
//   i_wr    1 = write, 0 = read (qualified by i_en)
//   i_addr  register select
//   i_data  write data
//   o_data  read data, one cycle after the read strobe, held until next read
//   o_irq   registered STATUS.expired & CTRL.ie
//   o_out   (only with BUS_TIMER_PWM_OUT_EN) toggles on every expiry
//
// Build option: define BUS_TIMER_PWM_OUT_EN to add the o_out square-wave
// output and the CTRL.out_force_low bit.
// ---------------------------------------------------------------------------
module bus_timer #(
  parameter logic [7:0]  PRESCALE_INIT = 8'd0,
  parameter logic [15:0] RELOAD_INIT   = 16'd0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_wr,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_irq
`ifdef BUS_TIMER_PWM_OUT_EN
  ,
  output logic       o_out
`endif
);

  localparam logic [3:0] A_CTRL     = 4'd0;
  localparam logic [3:0] A_PRESCALE = 4'd1;
  localparam logic [3:0] A_RELOAD_L = 4'd2;
  localparam logic [3:0] A_RELOAD_H = 4'd3;
  localparam logic [3:0] A_COUNT_L  = 4'd4;
  localparam logic [3:0] A_COUNT_H  = 4'd5;
  localparam logic [3:0] A_STATUS   = 4'd6;

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      r_state, w_next;
  logic        r_auto, r_ie, r_expired, r_irq;
  logic [7:0]  r_prescale, r_pscnt, r_shadow, r_data;
  logic [15:0] r_reload, r_count;

  logic       w_wr, w_rd, w_ctrl_wr;
  logic       w_start, w_stop_wr, w_tick, w_expire;
  logic [7:0] w_rdata;

`ifdef BUS_TIMER_PWM_OUT_EN
  logic r_force_low, r_out;
`endif

  assign w_wr      = i_en & i_wr;
  assign w_rd      = i_en & ~i_wr;
  assign w_ctrl_wr = w_wr && (i_addr == A_CTRL);

  // ---------------------------------------------------------------------
  // Control FSM: next state plus the strobes the datapath acts on.
  // ---------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_stop_wr = 1'b0;
    w_tick    = 1'b0;
    w_expire  = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (w_ctrl_wr && i_data[0]) begin
          w_start = 1'b1;
          w_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        // An explicit stop freezes COUNT; it overrides a coincident tick.
        w_stop_wr = w_ctrl_wr && !i_data[0];
        w_tick    = (r_pscnt == r_prescale) && !w_stop_wr;
        w_expire  = w_tick && (r_count == 16'd0);
        if (w_stop_wr)
          w_next = ST_STOP;
        else if (w_expire && !r_auto)
          w_next = ST_STOP;
      end
      default: w_next = ST_STOP;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_STOP;
    else       r_state <= w_next;
  end

  // ---------------------------------------------------------------------
  // Read mux. CTRL.en is simply the FSM state.
  // ---------------------------------------------------------------------
  always_comb begin
    w_rdata = 8'h00;
    case (i_addr)
`ifdef BUS_TIMER_PWM_OUT_EN
      A_CTRL:     w_rdata = {4'b0, r_force_low, r_ie, r_auto, r_state == ST_RUN};
`else
      A_CTRL:     w_rdata = {5'b0, r_ie, r_auto, r_state == ST_RUN};
`endif
      A_PRESCALE: w_rdata = r_prescale;
      A_RELOAD_L: w_rdata = r_reload[7:0];
      A_RELOAD_H: w_rdata = r_reload[15:8];
      A_COUNT_L:  w_rdata = r_count[7:0];
      A_COUNT_H:  w_rdata = r_shadow;
      A_STATUS:   w_rdata = {7'b0, r_expired};
      default:    w_rdata = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers and datapath.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_auto     <= 1'b0;
      r_ie       <= 1'b0;
      r_expired  <= 1'b0;
      r_irq      <= 1'b0;
      r_prescale <= PRESCALE_INIT;
      r_pscnt    <= 8'd0;
      r_shadow   <= 8'd0;
      r_data     <= 8'd0;
      r_reload   <= RELOAD_INIT;
      r_count    <= 16'd0;
    end else begin
      if (w_ctrl_wr) begin
        r_auto <= i_data[1];
        r_ie   <= i_data[2];
      end
      if (w_wr && i_addr == A_PRESCALE) r_prescale     <= i_data;
      if (w_wr && i_addr == A_RELOAD_L) r_reload[7:0]  <= i_data;
      if (w_wr && i_addr == A_RELOAD_H) r_reload[15:8] <= i_data;

      // Prescaler free-runs (8-bit wrap) while running; a PRESCALE lowered
      // below the current count therefore waits for a full wrap.
      if (w_start)
        r_pscnt <= 8'd0;
      else if (r_state == ST_RUN && !w_stop_wr)
        r_pscnt <= w_tick ? 8'd0 : r_pscnt + 8'd1;

      if (w_start)
        r_count <= r_reload;
      else if (w_expire && r_auto)
        r_count <= r_reload;
      else if (w_tick && r_count != 16'd0)
        r_count <= r_count - 16'd1;

      // Expiry beats a same-edge clear.
      if (w_expire)
        r_expired <= 1'b1;
      else if (w_wr && i_addr == A_STATUS)
        r_expired <= 1'b0;

      r_irq <= r_expired & r_ie;

      if (w_rd && i_addr == A_COUNT_L) r_shadow <= r_count[15:8];
      if (w_rd)                        r_data   <= w_rdata;
    end
  end

`ifdef BUS_TIMER_PWM_OUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_force_low <= 1'b0;
      r_out       <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_force_low <= i_data[3];
      if (w_expire)  r_out       <= ~r_out;
    end
  end

  // The wave keeps its phase underneath the force so releasing it resumes
  // in step with the counter.
  assign o_out = r_out & ~r_force_low;
`endif

  assign o_data = r_data;
  assign o_irq  = r_irq;

endmodule

// File: tb/tb_bus_timer.sv
module tb_bus_timer;

  localparam logic [7:0]  PI = 8'h05;
  localparam logic [15:0] RI = 16'h0A3C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, wr = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata;
  logic       irq;
`ifdef BUS_TIMER_PWM_OUT_EN
  logic       pwm;
`endif

  int nvec = 0;
  int nerr = 0;

  bus_timer #(.PRESCALE_INIT(PI), .RELOAD_INIT(RI)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_wr(wr), .i_addr(addr),
    .i_data(wdata), .o_data(rdata), .o_irq(irq)
`ifdef BUS_TIMER_PWM_OUT_EN
    , .o_out(pwm)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bwr(input logic [3:0] a, input logic [7:0] d);
    en = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic brd(input logic [3:0] a, output logic [7:0] d);
    en = 1'b1; wr = 1'b0; addr = a;
    @(posedge clk); #1;
    en = 1'b0;
    d = rdata;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    logic [7:0] d;
    logic [7:0] exp [8];
    exp = '{8'h00, PI, RI[7:0], RI[15:8], 8'h00, 8'h00, 8'h00, 8'h00};
    chk({tag, "_irq"}, {7'b0, irq}, 8'h00);
    for (int a = 0; a < 8; a++) begin
      brd(a[3:0], d);
      chk($sformatf("%s_rd%0d", tag, a), d, exp[a]);
    end
  endtask

  // Reference model: closed-form register values k cycles after the start
  // write (k = 0 is just after the start edge).
  int m_p, m_r, m_auto;
  function automatic int m_cnt(input int k);
    int t = k / (m_p + 1);
    if (m_auto != 0) return m_r - (t % (m_r + 1));
    if (t >= m_r + 1) return 0;
    return m_r - t;
  endfunction
  function automatic int m_exp(input int k);
    return ((k / (m_p + 1)) >= m_r + 1) ? 1 : 0;
  endfunction

  initial begin
    logic [7:0] d;
    int n, ie, c;
    logic [15:0] cv;
    logic [7:0] ctl;

    idle(2);
    rst = 1'b0;

    // --- reset state, unmapped space
    check_reset_vals("rst");
    bwr(4'd9, 8'hFF);
    brd(4'd12, d); chk("unmapped_rd", d, 8'h00);

    // --- one-shot: P=3, R=4 expires 20 cycles after the start write
    bwr(4'd1, 8'd3); bwr(4'd2, 8'd4); bwr(4'd3, 8'd0);
    bwr(4'd0, 8'h01);
    idle(19);
    brd(4'd6, d); chk("oneshot_pre", d, 8'h00);
    brd(4'd6, d); chk("oneshot_exp", d, 8'h01);
    brd(4'd0, d); chk("oneshot_ctrl", d, 8'h00);
    idle(10);
    brd(4'd4, d); chk("oneshot_cnt", d, 8'h00);

    // --- auto-reload irq, P=0, R=2: expiry every 3 cycles
    do_reset();
    bwr(4'd1, 8'd0); bwr(4'd2, 8'd2); bwr(4'd3, 8'd0);
    bwr(4'd0, 8'h07);
    idle(3); chk("irq_w3", {7'b0, irq}, 8'h00);
    idle(1); chk("irq_w4", {7'b0, irq}, 8'h01);
    bwr(4'd6, 8'h5A); chk("irq_w5", {7'b0, irq}, 8'h01);
    idle(1); chk("irq_w6", {7'b0, irq}, 8'h00);
    idle(1); chk("irq_w7", {7'b0, irq}, 8'h01);
    idle(1);
    bwr(4'd6, 8'h00);                       // lands on expiry edge W+9
    brd(4'd6, d); chk("clr_vs_expiry", d, 8'h01);

    // --- COUNT shadow
    do_reset();
    bwr(4'd1, 8'd0); bwr(4'd2, 8'h34); bwr(4'd3, 8'h12);
    bwr(4'd0, 8'h01);
    brd(4'd5, d); chk("shadow_stale", d, 8'h00);
    brd(4'd4, d); chk("count_lo", d, 8'h33);
    idle(64);
    brd(4'd5, d); chk("count_hi_shadow", d, 8'h12);
    brd(4'd4, d); chk("count_lo_moved", d, 8'hF1);
    do_reset();
    check_reset_vals("midrst");

    // --- PRESCALE lowered below the running prescale count wraps via 255
    do_reset();
    bwr(4'd1, 8'd7); bwr(4'd2, 8'd0); bwr(4'd3, 8'd0);
    bwr(4'd0, 8'h03);
    idle(5);
    bwr(4'd1, 8'd2);
    idle(252);
    brd(4'd6, d); chk("wrap_noearly", d, 8'h00);
    brd(4'd6, d); chk("wrap_tick", d, 8'h01);

`ifdef BUS_TIMER_PWM_OUT_EN
    // --- PWM: P=1, R=1 -> toggle every 4 cycles
    do_reset();
    bwr(4'd1, 8'd1); bwr(4'd2, 8'd1); bwr(4'd3, 8'd0);
    bwr(4'd0, 8'h03);
    idle(3); chk("pwm_w3", {7'b0, pwm}, 8'h00);
    idle(1); chk("pwm_w4", {7'b0, pwm}, 8'h01);
    idle(3); chk("pwm_w7", {7'b0, pwm}, 8'h01);
    idle(1); chk("pwm_w8", {7'b0, pwm}, 8'h00);
    idle(4); chk("pwm_w12", {7'b0, pwm}, 8'h01);
    bwr(4'd0, 8'h0B);
    for (int i = 0; i < 6; i++) begin
      chk("pwm_force", {7'b0, pwm}, 8'h00);
      idle(1);
    end
    brd(4'd0, d); chk("pwm_ctrl_rd", d, 8'h0B);
`else
    bwr(4'd0, 8'h08);
    brd(4'd0, d); chk("ctrl_bit3_ro", d, 8'h00);
`endif

    // --- randomized runs against the closed-form model
    for (int it = 0; it < 10; it++) begin
      do_reset();
      m_p    = $urandom_range(0, 3);
      m_r    = $urandom_range(0, 600);
      m_auto = $urandom_range(0, 1);
      ie     = $urandom_range(0, 1);
      n      = $urandom_range(0, (m_r + 1) * (m_p + 1) + 20);
      cv     = 16'(m_r);
      bwr(4'd1, 8'(m_p));
      bwr(4'd2, cv[7:0]);
      bwr(4'd3, cv[15:8]);
      ctl = {5'b0, ie[0], m_auto[0], 1'b1};
      bwr(4'd0, ctl);
      idle(n);
      c  = m_cnt(n);
      cv = 16'(c);
      brd(4'd4, d); chk($sformatf("rnd%0d_lo", it), d, cv[7:0]);
      chk($sformatf("rnd%0d_irq", it), {7'b0, irq}, 8'(m_exp(n) & ie));
      brd(4'd5, d); chk($sformatf("rnd%0d_hi", it), d, cv[15:8]);
      brd(4'd6, d); chk($sformatf("rnd%0d_st", it), d, 8'(m_exp(n + 2)));
      ctl[0] = (m_auto != 0) ? 1'b1 : (m_exp(n + 3) == 0);
      brd(4'd0, d); chk($sformatf("rnd%0d_ctrl", it), d, ctl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
